// File: rtl/beta_store_buffer.sv
// beta_store_buffer
// Posted-write buffer between the Beta CPU memory stage and the data memory.
// CPU stores are queued in a small FIFO. They are retired to memory, one per
// cycle, on every cycle in which cpu_re is low. Loads get the memory port
// with zero latency and observe pending stores in program order.
//
// Configuration macro: BETA_SB_FWD_EN
//   defined   - a load that hits a pending store is served from the newest
//               matching entry in the same cycle.
//   undefined - a load that hits a pending store stalls. The buffer keeps
//               draining until no match remains, then the load reads memory.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata     CPU byte address / store data
//   cpu_we / cpu_re        store / load request (both high: store wins)
//   cpu_rdata              load data (combinational)
//   stall                  CPU must hold its current request
//   flush                  block new stores until the buffer is empty
//   empty                  no pending stores
//   mem_addr/mem_wdata     data-memory address / write data
//   mem_we / mem_re        data-memory MemWrite / MemRead
//   mem_rdata              data-memory read data (combinational)
module beta_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  input  logic        flush,
  output logic        empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full;
  logic             ld;
  logic             match;
  logic             ld_hold;
  logic             st_block;
  logic             accept;
  logic             drain;
  logic [PTR_W-1:0] idx;
`ifdef BETA_SB_FWD_EN
  logic [31:0]      fwd_data;
`endif

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign ld    = cpu_re & ~cpu_we;

  // Scan the valid entries oldest to newest, starting at head. A later hit
  // overrides an earlier one, so the newest store to the word wins. Slots
  // outside the count window are stale and never take part.
  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef BETA_SB_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_q[idx] == cpu_addr[31:2])) begin
        match = 1'b1;
`ifdef BETA_SB_FWD_EN
        fwd_data = data_q[idx];
`endif
      end
    end
  end

`ifdef BETA_SB_FWD_EN
  assign ld_hold = 1'b0;
`else
  // Without forwarding, a load that hits a pending store waits while the
  // buffer drains past every matching entry.
  assign ld_hold = ld & match;
`endif

  // Store blocking looks only at occupancy and flush, never at this cycle's
  // drain, so the CPU sees no combinational path through the drain decision.
  assign st_block = full | (flush & ~empty);
  assign accept   = cpu_we & ~st_block;
  assign drain    = ~empty & (~cpu_re | ld_hold);

  always_comb begin
    stall     = 1'b0;
    mem_we    = drain;
    mem_re    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = data_q[head_q];
    cpu_rdata = '0;
    if (drain) begin
      mem_addr = {addr_q[head_q], 2'b00};
    end
    if (reset_n) begin
      stall  = (cpu_we & st_block) | ld_hold;
      mem_re = ld & ~ld_hold;
      if (ld && !ld_hold) begin
`ifdef BETA_SB_FWD_EN
        cpu_rdata = match ? fwd_data : mem_rdata;
`else
        cpu_rdata = mem_rdata;
`endif
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + 1'b1;
    end
    if (accept) begin
      tail_d = tail_q + 1'b1;
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: only slots inside the count window are
  // ever observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= cpu_addr[31:2];
      data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_beta_store_buffer.sv
module tb_beta_store_buffer;

  localparam int unsigned DEPTH = 4;
`ifdef BETA_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        flush;
  logic        empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  beta_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .flush     (flush),
    .empty     (empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem: the physical memory, written only by what the DUT drives out.
  // mmem: the bench's idea of memory contents, written by predicted drains.
  logic [31:0] dmem [256];
  logic [31:0] mmem [256];
  assign mem_rdata = dmem[mem_addr[9:2]];

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic        stall;
    logic        drain;
    logic        empty;
    logic        mre;
    logic [31:0] maddr;
    logic [31:0] rdata;
  } pred_t;

  ent_t mq[$];  // model of pending stores, oldest first
  ent_t sb[$];  // scoreboard of expected memory writes
  ent_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Drive one cycle of stimulus at the negedge and predict the DUT response
  // from the bench's own model; the model is advanced for the coming posedge.
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic fl, output pred_t p);
    bit          ld, hit, acc;
    logic [31:0] fv;
    ent_t        e;
    @(negedge clk);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd; flush = fl;
    ld  = re && !we;
    hit = 1'b0;
    fv  = mmem[a[9:2]];
    foreach (mq[i]) begin
      if (mq[i].wa == a[31:2]) begin
        hit = 1'b1;
        fv  = mq[i].d;
      end
    end
    p.empty = (mq.size() == 0);
    p.drain = !p.empty && (!re || (!FWD && ld && hit));
    if (we) p.stall = (mq.size() == DEPTH) || (fl && !p.empty);
    else    p.stall = ld && !FWD && hit;
    acc     = we && !p.stall;
    p.mre   = ld && !p.stall;
    p.maddr = p.drain ? {mq[0].wa, 2'b00} : a;
    p.rdata = p.mre ? fv : 32'h0;
    #1;
    if (p.drain) begin
      e = mq.pop_front();
      mmem[e.wa[7:0]] = e.d;
    end
    if (acc) begin
      e.wa = a[31:2];
      e.d  = wd;
      mq.push_back(e);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    pred_t p;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h3F0, 32'h0, 1'b0, p);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cpu_we = 1'b0; cpu_re = 1'b0; flush = 1'b0;
    mq.delete();
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Every memory write the DUT issues must be the oldest outstanding store.
  always @(negedge clk) begin
    #3;
    if (reset_n && mem_we) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL drain_spurious: mem_we=1 addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (mem_addr !== {mon_e.wa, 2'b00} || mem_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL drain_order: got %h/%h required %h/%h", mem_addr, mem_wdata, {mon_e.wa, 2'b00}, mon_e.d);
        end
      end
      dmem[mem_addr[9:2]] = mem_wdata;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_we = 1'b0; cpu_re = 1'b0; flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({empty, stall, mem_we, mem_re} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got e/s/we/re=%b required 1000", {empty, stall, mem_we, mem_re});
    end
    n_checks++;
    if (cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 00000000", cpu_rdata);
    end
  endtask

  task automatic test_reset_mid();
    pred_t p;
    step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, p);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, p);
      n_checks++;
      if (cpu_rdata !== p.rdata || mem_we !== 1'b0 || mem_re !== 1'b1) begin
        n_fail++;
        $display("FAIL held_load: got rdata=%h we=%b re=%b required %h 0 1", cpu_rdata, mem_we, mem_re, p.rdata);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({empty, mem_we, stall, mem_re} !== 4'b1000 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got e/we/s/re=%b rdata=%h required 1000 00000000", {empty, mem_we, stall, mem_re}, cpu_rdata);
    end
    mq.delete();
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, p);
    n_checks++;
    if (cpu_rdata !== 32'hA0000004 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_load: got rdata=%h stall=%b required A0000004 0", cpu_rdata, stall);
    end
  endtask

  task automatic test_fill_stall();
    pred_t p;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'h80 + 4*k, 32'hF0F0_0000 + k, 1'b0, p);
      n_checks++;
      if (stall !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: got stall=%b we=%b required 0 0", k, stall, mem_we);
      end
    end
    step(1'b1, 1'b1, 32'h90, 32'h5555_5555, 1'b0, p);
    n_checks++;
    if (stall !== 1'b1 || stall !== p.stall) begin
      n_fail++;
      $display("FAIL fifth_stall: got %b required 1", stall);
    end
    step(1'b1, 1'b0, 32'h90, 32'h5555_5555, 1'b0, p);
    n_checks++;
    if (stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL full_drain: got stall=%b we=%b addr=%h required 1 1 00000080", stall, mem_we, mem_addr);
    end
    step(1'b1, 1'b1, 32'h90, 32'h5555_5555, 1'b0, p);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fifth_accept: got stall=%b required 0", stall);
    end
    step(1'b1, 1'b1, 32'h94, 32'h6666_6666, 1'b0, p);
    n_checks++;
    if (stall !== 1'b1 || stall !== p.stall) begin
      n_fail++;
      $display("FAIL refull_stall: got %b required 1", stall);
    end
    idle(5);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_empty: got %b required 1", empty);
    end
  endtask

  task automatic test_forward_newest();
    pred_t p;
    int    nst = 0;
    step(1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0, p);
    step(1'b1, 1'b1, 32'h20, 32'h22222222, 1'b0, p);
    for (int g = 0; g < 6; g++) begin
      step(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, p);
      if (stall) nst++;
      n_checks++;
      if (stall !== p.stall || mem_re !== p.mre) begin
        n_fail++;
        $display("FAIL fwd_stall_%0d: got stall=%b re=%b required %b %b", g, stall, mem_re, p.stall, p.mre);
      end
      if (!p.stall) begin
        n_checks++;
        if (cpu_rdata !== 32'h22222222) begin
          n_fail++;
          $display("FAIL fwd_newest: got %h required 22222222", cpu_rdata);
        end
        break;
      end
    end
    n_checks++;
    if (nst !== (FWD ? 0 : 2)) begin
      n_fail++;
      $display("FAIL fwd_stall_cycles: got %0d required %0d", nst, FWD ? 0 : 2);
    end
    idle(3);
  endtask

  task automatic test_drain_order();
    pred_t       p;
    logic [31:0] ea;
    step(1'b1, 1'b1, 32'h0, 32'hAAAA0000, 1'b0, p);
    step(1'b1, 1'b1, 32'h4, 32'hBBBB0004, 1'b0, p);
    step(1'b1, 1'b1, 32'h8, 32'hCCCC0008, 1'b0, p);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, p);
      ea = 4 * k;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== ea || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_%0d: got we=%b addr=%h empty=%b required 1 %h 0", k, mem_we, mem_addr, empty, ea);
      end
    end
    step(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, p);
    n_checks++;
    if (empty !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_done: got e=%b we=%b addr=%h rdata=%h required 1 0 00000300 00000000", empty, mem_we, mem_addr, cpu_rdata);
    end
  endtask

  task automatic test_wrap();
    pred_t p;
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, (k == 5) ? 32'h204 : 32'h200 + 4*k, 32'h7000_0000 + k, 1'b0, p);
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_store_%0d: got stall=%b required 0", k, stall);
      end
      if (k < 5) idle(1);
    end
    for (int g = 0; g < 4; g++) begin
      step(1'b0, 1'b1, 32'h204, 32'h0, 1'b0, p);
      if (!p.stall) begin
        n_checks++;
        if (cpu_rdata !== 32'h70000005) begin
          n_fail++;
          $display("FAIL wrap_fwd: got %h required 70000005", cpu_rdata);
        end
        break;
      end
    end
    step(1'b0, 1'b1, 32'h208, 32'h0, 1'b0, p);
    n_checks++;
    if (cpu_rdata !== 32'h70000002 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_retired: got rdata=%h stall=%b required 70000002 0", cpu_rdata, stall);
    end
    idle(2);
  endtask

  task automatic test_flush();
    pred_t p;
    int    nst = 0;
    step(1'b1, 1'b1, 32'h300, 32'h3000_0000, 1'b0, p);
    step(1'b1, 1'b1, 32'h304, 32'h3000_0004, 1'b0, p);
    step(1'b1, 1'b1, 32'h308, 32'h3000_0008, 1'b0, p);
    for (int g = 0; g < 8; g++) begin
      step(1'b1, 1'b0, 32'h30C, 32'h3000_000C, 1'b1, p);
      if (stall) nst++;
      n_checks++;
      if (stall !== p.stall || mem_we !== p.drain || empty !== p.empty) begin
        n_fail++;
        $display("FAIL flush_%0d: got s/we/e=%b%b%b required %b%b%b", g, stall, mem_we, empty, p.stall, p.drain, p.empty);
      end
      if (!p.stall) break;
    end
    n_checks++;
    if (nst !== 3) begin
      n_fail++;
      $display("FAIL flush_stall_cycles: got %0d required 3", nst);
    end
    flush = 1'b0;
    idle(3);
    n_checks++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_end: got empty=%b outstanding=%0d required 1 0", empty, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 32'hA000_0000 + i;
      mmem[i] = 32'hA000_0000 + i;
    end
    test_reset();
    test_reset_mid();
    test_fill_stall();
    test_forward_newest();
    test_drain_order();
    test_wrap();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
